// File: rtl/ppm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppm_pkg
// Description : Shared types, constants and helpers for the PPM symbol decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ppm_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int PPM_SLOTS     = 4;
    localparam int BITS_PER_SYM  = 2;
    localparam int SYMS_PER_BYTE = 4;

    function automatic logic [2:0] popcount4(input logic [PPM_SLOTS-1:0] v);
        logic [2:0] sum;
        sum = 3'd0;
        for (int i = 0; i < PPM_SLOTS; i++) begin
            sum = sum + {2'b00, v[i]};
        end
        return sum;
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic logic [BITS_PER_SYM-1:0] onehot_idx(input logic [PPM_SLOTS-1:0] v);
        logic [BITS_PER_SYM-1:0] idx;
        idx = '0;
        for (int i = 0; i < PPM_SLOTS; i++) begin
            if (v[i]) begin
                idx = BITS_PER_SYM'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppm_slot_sampler.sv
`default_nettype none
// ============================================================================
// Module      : ppm_slot_sampler
// Description : Counts ticks and low samples within one PPM slot; flags slot end.
// Revision    : 1.0 - initial release
// ============================================================================
module ppm_slot_sampler #(
    parameter int SLOT_TICKS = 8,
    parameter int HIT_MIN    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic run,
    input  logic restart,
    input  logic din,
    output logic slot_done,
    output logic hit
);

    localparam int TW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam int LW = $clog2(SLOT_TICKS + 1);

    logic [TW-1:0] tick_cnt;
    logic [LW-1:0] low_cnt;
    logic [LW-1:0] low_next;
    logic          last_tick;

    // The closing tick's own sample must count toward the hit decision.
    always_comb begin
        low_next = low_cnt;
        if (!din && (low_cnt != LW'(SLOT_TICKS))) begin
            low_next = low_cnt + 1'b1;
        end
    end

    assign last_tick = (tick_cnt == TW'(SLOT_TICKS - 1));
    assign slot_done = tick && run && !restart && last_tick;
    assign hit       = (low_next >= LW'(HIT_MIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            low_cnt  <= '0;
        end else if (tick) begin
            if (!run || restart || last_tick) begin
                tick_cnt <= '0;
                low_cnt  <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
                low_cnt  <= low_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppm_symbol_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ppm_symbol_decoder
// Description : Slices 1-of-4 PPM symbols after SOF, assembles bytes LSB-first,
//               and reports EOF, symbol errors and frame overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module ppm_symbol_decoder
    import ppm_pkg::*;
#(
    parameter int SLOT_TICKS = 8,
    parameter int HIT_MIN    = 2,
    parameter int MAX_BYTES  = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk16,
    input  logic             Din,
    input  logic             sof_rcv_in,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             eof_rcv_out,
    output logic             sym_err,
    output logic             busy
);

    localparam int BYTE_W = BITS_PER_SYM * SYMS_PER_BYTE;

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              slot_idx;
    logic [1:0]              sym_idx;
    logic [PPM_SLOTS-1:0]    hits;
    logic [PPM_SLOTS-1:0]    hits_all;
    logic [BYTE_W-1:0]       shift_reg;
    logic [BYTE_W-1:0]       shift_new;
    logic [BITS_PER_SYM-1:0] sym_val;
    logic [2:0]              n_hits;
    logic                    sof_tick;
    logic                    slot_done;
    logic                    hit;
    logic                    sym_end;
    logic                    byte_done;
    logic                    overflow;
    logic                    frame_eof;
    logic                    frame_err;

    assign sof_tick = clk16 && sof_rcv_in;

    ppm_slot_sampler #(
        .SLOT_TICKS (SLOT_TICKS),
        .HIT_MIN    (HIT_MIN)
    ) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .tick      (clk16),
        .run       (state == RECV),
        .restart   (sof_rcv_in),
        .din       (Din),
        .slot_done (slot_done),
        .hit       (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Symbol judgement: sof outranks everything, since slot_done is masked by it.
    always_comb begin
        hits_all  = hits;
        if (slot_done) begin
            hits_all[slot_idx] = hit;
        end
        n_hits    = popcount4(hits_all);
        sym_val   = onehot_idx(hits_all);
        shift_new = shift_reg;
        shift_new[{sym_idx, 1'b0} +: BITS_PER_SYM] = sym_val;

        sym_end   = slot_done && (slot_idx == 2'(PPM_SLOTS - 1));
        byte_done = sym_end && (n_hits == 3'd1) && (sym_idx == 2'(SYMS_PER_BYTE - 1));
        overflow  = byte_done && (byte_cnt == CNT_W'(MAX_BYTES));
        frame_eof = sym_end && (n_hits == 3'd0) && (sym_idx == 2'd0);
        frame_err = (sym_end && (n_hits != 3'd1) && !frame_eof) || overflow;

        state_next = state;
        if (sof_tick) begin
            state_next = RECV;
        end else if ((state == RECV) && (frame_eof || frame_err)) begin
            state_next = IDLE;
        end

        busy = (state == RECV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_idx    <= '0;
            sym_idx     <= '0;
            hits        <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            byte_cnt    <= '0;
            eof_rcv_out <= 1'b0;
            sym_err     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            sym_err    <= 1'b0;
            if (clk16) begin
                eof_rcv_out <= 1'b0;
                if (sof_rcv_in) begin
                    slot_idx  <= '0;
                    sym_idx   <= '0;
                    hits      <= '0;
                    shift_reg <= '0;
                    byte_cnt  <= '0;
                end else if (slot_done) begin
                    slot_idx <= slot_idx + 2'd1;
                    hits     <= hits_all;
                    if (sym_end) begin
                        hits <= '0;
                        if (frame_eof || frame_err) begin
                            eof_rcv_out <= 1'b1;
                            sym_err     <= frame_err;
                            sym_idx     <= '0;
                            shift_reg   <= '0;
                        end else begin
                            sym_idx   <= sym_idx + 2'd1;
                            shift_reg <= shift_new;
                            if (byte_done) begin
                                data_out   <= shift_new;
                                data_valid <= 1'b1;
                                byte_cnt   <= byte_cnt + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppm_symbol_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppm_symbol_decoder
// Description : Directed self-checking bench for ppm_symbol_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppm_symbol_decoder;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clk16 = 1'b0;
    logic             Din = 1'b1;
    logic             sof_rcv_in = 1'b0;
    logic [7:0]       data_out;
    logic             data_valid;
    logic [CNT_W-1:0] byte_cnt;
    logic             eof_rcv_out;
    logic             sym_err;
    logic             busy;

    always #5 clk = ~clk;

    ppm_symbol_decoder #(
        .SLOT_TICKS (8),
        .HIT_MIN    (2),
        .MAX_BYTES  (2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk16       (clk16),
        .Din         (Din),
        .sof_rcv_in  (sof_rcv_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .byte_cnt    (byte_cnt),
        .eof_rcv_out (eof_rcv_out),
        .sym_err     (sym_err),
        .busy        (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event monitor: totals only ever grow; scenarios compare against snapshots.
    int         dv_total  = 0;
    int         eof_total = 0;
    int         err_total = 0;
    int         bad_lat   = 0;
    logic       prev_tick = 1'b0;
    logic [7:0] bytes_q[$];

    always @(posedge clk) begin
        if (!rst) begin
            if (data_valid) begin
                dv_total++;
                bytes_q.push_back(data_out);
                if (!prev_tick) bad_lat++;
            end
            if (clk16 && eof_rcv_out) eof_total++;
            if (sym_err) err_total++;
        end
        prev_tick = clk16;
    end

    int dv0, eof0, err0;

    task automatic mark();
        dv0  = dv_total;
        eof0 = eof_total;
        err0 = err_total;
    endtask

    task automatic send_tick(input logic din, input logic sof);
        @(negedge clk);
        clk16      = 1'b1;
        Din        = din;
        sof_rcv_in = sof;
        @(negedge clk);
        clk16      = 1'b0;
        sof_rcv_in = 1'b0;
        Din        = 1'b1;
    endtask

    task automatic send_slot(input int lows);
        for (int t = 0; t < 8; t++) send_tick(!(t >= 2 && t < 2 + lows), 1'b0);
    endtask

    task automatic send_sym(input logic [3:0] mask);
        for (int s = 0; s < 4; s++) send_slot(mask[s] ? 4 : 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) send_sym(4'b0001 << b[2*i +: 2]);
    endtask

    task automatic send_sof();
        send_tick(1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_tick(1'b1, 1'b0);
    endtask

    task automatic expect_frame(input string tag, input int dv, input int eof, input int err, input int cnt);
        check({tag, "_dv"},   dv_total - dv0,   dv);
        check({tag, "_eof"},  eof_total - eof0, eof);
        check({tag, "_err"},  err_total - err0, err);
        check({tag, "_cnt"},  32'(byte_cnt),    cnt);
        check({tag, "_busy"}, 32'(busy),        0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data",  32'(data_out),    0);
        check("rst_dv",    32'(data_valid),  0);
        check("rst_cnt",   32'(byte_cnt),    0);
        check("rst_eof",   32'(eof_rcv_out), 0);
        check("rst_err",   32'(sym_err),     0);
        check("rst_busy",  32'(busy),        0);

        // Slots 0,1,3,2 -> 0xB4, then empty symbol.
        mark();
        send_sof();
        check("t1_busy_up", 32'(busy), 1);
        send_sym(4'b0001); send_sym(4'b0010); send_sym(4'b1000); send_sym(4'b0100);
        send_sym(4'b0000);
        idle(4);
        expect_frame("t1", 1, 1, 0, 1);
        check("t1_byte", 32'(bytes_q[dv0]), 32'hB4);

        // Two bytes 0x00, 0xFF.
        mark();
        send_sof();
        send_byte(8'h00); send_byte(8'hFF);
        send_sym(4'b0000);
        idle(4);
        expect_frame("t2", 2, 1, 0, 2);
        check("t2_byte0", 32'(bytes_q[dv0]),     32'h00);
        check("t2_byte1", 32'(bytes_q[dv0 + 1]), 32'hFF);

        // Double hit error, then a clean frame.
        mark();
        send_sof();
        send_sym(4'b0110);
        idle(4);
        expect_frame("t3a", 0, 1, 1, 0);
        mark();
        send_sof();
        send_byte(8'h3C);
        send_sym(4'b0000);
        idle(4);
        expect_frame("t3b", 1, 1, 0, 1);
        check("t3b_byte", 32'(bytes_q[dv0]), 32'h3C);

        // Empty symbol mid-byte.
        mark();
        send_sof();
        send_sym(4'b0001); send_sym(4'b0100);
        send_sym(4'b0000);
        idle(4);
        expect_frame("t4", 0, 1, 1, 0);

        // One-sample glitch in slot 0 is ignored; pulse in slot 3 wins.
        mark();
        send_sof();
        send_slot(1); send_slot(0); send_slot(0); send_slot(4);
        send_sym(4'b0001); send_sym(4'b0001); send_sym(4'b0001);
        send_sym(4'b0000);
        idle(4);
        expect_frame("t5", 1, 1, 0, 1);
        check("t5_byte", 32'(bytes_q[dv0]), 32'h03);

        // Resync mid-byte.
        mark();
        send_sof();
        send_sym(4'b0010);
        send_sof();
        send_byte(8'h5A);
        send_sym(4'b0000);
        idle(4);
        expect_frame("t6", 1, 1, 0, 1);
        check("t6_byte", 32'(bytes_q[dv0]), 32'h5A);

        // Overflow on third byte with a two-byte limit.
        mark();
        send_sof();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        idle(4);
        expect_frame("t7", 2, 1, 1, 2);
        check("t7_byte1", 32'(bytes_q[dv0 + 1]), 32'h22);
        check("t7_last",  32'(data_out),         32'h22);

        // Reset mid-byte.
        mark();
        send_sof();
        send_byte(8'hC3);
        send_sym(4'b0100); send_sym(4'b0001);
        check("t8_busy_up", 32'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t8_data", 32'(data_out), 0);
        idle(4);
        expect_frame("t8", 1, 0, 0, 0);

        check("latency", bad_lat, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
